// File: rtl/adc_frame_sequencer_if.sv
// rtl/adc_frame_sequencer_if.sv - control, capture and result signals of the ADC frame sequencer
interface adc_frame_sequencer_if;
   logic        enable;
   logic        start;
   logic [11:0] adc_bus;
   logic        spi_clock;
   logic        adc_ss;
   logic [11:0] sample;
   logic        sample_valid;
   logic        busy;
   logic [15:0] frame_count;

   modport master (
      input  enable, start, adc_bus,
      output spi_clock, adc_ss, sample, sample_valid, busy, frame_count
   );

   modport slave (
      output enable, start, adc_bus,
      input  spi_clock, adc_ss, sample, sample_valid, busy, frame_count
   );
endinterface

// File: rtl/adc_frame_sequencer.sv
// rtl/adc_frame_sequencer.sv - SPI clock divider and ADC select framing with sample latch
// One frame: SETUP, 16 SPI clocks, HOLD, LATCH, a flush clock with select high, then a quiet gap.
module adc_frame_sequencer #(
   parameter int CLK_DIV     = 25,
   parameter int IDLE_CYCLES = 50,
   parameter int FREE_RUN    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   adc_frame_sequencer_if.master bus
);
   localparam int SPAN = (CLK_DIV > IDLE_CYCLES) ? CLK_DIV : IDLE_CYCLES;
   localparam int CW   = $clog2(SPAN + 1);
   localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
   localparam logic [4:0]    LAST_EDGE = 5'd16;

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, LATCH, FLUSH, GAP} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [4:0]    edge_cnt, edge_cnt_nx;
   logic          spi, spi_nx;
   logic          ss_r;
   logic [11:0]   sample_r;
   logic          valid_r;
   logic          busy_r;
   logic          discard;
   logic [15:0]   frame_count_r;
   logic          div_done;

   assign div_done = (cnt == DIV_LAST);

   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt + CW'(1);
      edge_cnt_nx = edge_cnt;
      spi_nx      = 1'b0;
      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (bus.enable && (FREE_RUN != 0 || bus.start)) state_nx = SETUP;
         end
         SETUP: begin
            if (div_done) begin
               state_nx    = SHIFT;
               cnt_nx      = '0;
               spi_nx      = 1'b1;
               edge_cnt_nx = 5'd1;
            end
         end
         SHIFT: begin
            spi_nx = spi;
            if (div_done) begin
               cnt_nx = '0;
               if (spi) begin
                  spi_nx = 1'b0;
               end else if (edge_cnt == LAST_EDGE) begin
                  state_nx = HOLD;
               end else begin
                  spi_nx      = 1'b1;
                  edge_cnt_nx = edge_cnt + 5'd1;
               end
            end
         end
         HOLD: begin
            if (div_done) begin
               state_nx = LATCH;
               cnt_nx   = '0;
            end
         end
         LATCH: begin
            state_nx = FLUSH;
            cnt_nx   = '0;
            spi_nx   = 1'b1;
         end
         // Rising edge with select high lets the capture stage clear its bit counter.
         FLUSH: begin
            spi_nx = spi;
            if (div_done) begin
               cnt_nx = '0;
               if (spi) spi_nx = 1'b0;
               else     state_nx = (IDLE_CYCLES == 0) ? IDLE : GAP;
            end
         end
         GAP: begin
            if (cnt == GAP_LAST) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         edge_cnt      <= '0;
         spi           <= 1'b0;
         ss_r          <= 1'b1;
         sample_r      <= '0;
         valid_r       <= 1'b0;
         busy_r        <= 1'b0;
         discard       <= 1'b1;
         frame_count_r <= '0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         edge_cnt <= edge_cnt_nx;
         spi      <= spi_nx;
         ss_r     <= !(state_nx inside {SETUP, SHIFT, HOLD});
         busy_r   <= (state_nx != IDLE);
         valid_r  <= 1'b0;
         // Outputs are registered from the next state so LATCH effects appear in the LATCH cycle.
         if (state_nx == LATCH) begin
            frame_count_r <= frame_count_r + 16'd1;
            discard       <= 1'b0;
            if (!discard) begin
               sample_r <= bus.adc_bus;
               valid_r  <= 1'b1;
            end
         end
      end
   end

   assign bus.spi_clock    = spi;
   assign bus.adc_ss       = ss_r;
   assign bus.sample       = sample_r;
   assign bus.sample_valid = valid_r;
   assign bus.busy         = busy_r;
   assign bus.frame_count  = frame_count_r;
endmodule

// File: tb/tb_adc_frame_sequencer.sv
// tb/tb_adc_frame_sequencer.sv - directed bench for adc_frame_sequencer
// Free-running and single-shot instances run with CLK_DIV=2, IDLE_CYCLES=4.
module tb_adc_frame_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   adc_frame_sequencer_if fr_if ();
   adc_frame_sequencer_if ss_if ();

   adc_frame_sequencer #(.CLK_DIV(2), .IDLE_CYCLES(4), .FREE_RUN(1)) dut_fr (
      .clk (clk),
      .rst (rst),
      .bus (fr_if)
   );

   adc_frame_sequencer #(.CLK_DIV(2), .IDLE_CYCLES(4), .FREE_RUN(0)) dut_ss (
      .clk (clk),
      .rst (rst),
      .bus (ss_if)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_frame_start(output logic found);
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (!fr_if.adc_ss) begin
            found = 1'b1;
            break;
         end
         tick(1);
      end
   endtask

   // Starts on a cycle with adc_ss low; stops at the next select fall or after 300 cycles.
   task automatic run_frame(input int drop_at, output int lows, output int rises_low,
                            output int rises_high, output int period, output int valids,
                            output logic [11:0] vsample);
      logic prev_spi, prev_ss;
      lows = 0; rises_low = 0; rises_high = 0; period = 0; valids = 0;
      vsample  = fr_if.sample;
      prev_spi = fr_if.spi_clock;
      prev_ss  = 1'b0;
      for (int n = 0; n < 300; n++) begin
         if (n == drop_at) fr_if.enable = 1'b0;
         if (!fr_if.adc_ss && prev_ss) begin
            period = n;
            break;
         end
         if (!fr_if.adc_ss) lows++;
         if (fr_if.spi_clock && !prev_spi) begin
            if (fr_if.adc_ss) rises_high++;
            else              rises_low++;
         end
         if (fr_if.sample_valid) begin
            valids++;
            vsample = fr_if.sample;
         end
         prev_spi = fr_if.spi_clock;
         prev_ss  = fr_if.adc_ss;
         tick(1);
      end
   endtask

   task automatic run_single(input int pulse_at, output int k, output int falls, output int valids);
      logic prev_ss;
      prev_ss = ss_if.adc_ss;
      k = 0; falls = 0; valids = 0;
      while (ss_if.busy && k < 500) begin
         ss_if.start = (k == pulse_at);
         if (ss_if.sample_valid) valids++;
         tick(1);
         k++;
         if (!ss_if.adc_ss && prev_ss) falls++;
         prev_ss = ss_if.adc_ss;
      end
      ss_if.start = 1'b0;
   endtask

   initial begin
      int          lows, rl, rh, per, vals, k, falls, rises, low_seen, busy_seen;
      logic [11:0] vs;
      logic        found, prev_spi;

      fr_if.enable = 1'b0; fr_if.start = 1'b0; fr_if.adc_bus = 12'hA5C;
      ss_if.enable = 1'b0; ss_if.start = 1'b0; ss_if.adc_bus = 12'h3C7;
      rst = 1'b1;
      tick(3);
      check("rst_ss", 32'(fr_if.adc_ss), 32'd1);
      check("rst_spi", 32'(fr_if.spi_clock), 32'd0);
      check("rst_busy", 32'(fr_if.busy), 32'd0);
      check("rst_sample", 32'(fr_if.sample), 32'h000);
      check("rst_valid", 32'(fr_if.sample_valid), 32'd0);
      check("rst_count", 32'(fr_if.frame_count), 32'd0);

      rst = 1'b0;
      rises = 0; low_seen = 0; busy_seen = 0;
      prev_spi = fr_if.spi_clock;
      for (int i = 0; i < 200; i++) begin
         tick(1);
         if (fr_if.spi_clock && !prev_spi) rises++;
         if (!fr_if.adc_ss) low_seen++;
         if (fr_if.busy) busy_seen++;
         prev_spi = fr_if.spi_clock;
      end
      check("quiet_rises", 32'(rises), 32'd0);
      check("quiet_ss_low", 32'(low_seen), 32'd0);
      check("quiet_busy", 32'(busy_seen), 32'd0);

      // Free-running frames: first discarded, second latched.
      fr_if.enable = 1'b1;
      wait_frame_start(found);
      check("f1_start", 32'(found), 32'd1);
      run_frame(-1, lows, rl, rh, per, vals, vs);
      check("f1_ss_low_cycles", 32'(lows), 32'd68);
      check("f1_rises_low", 32'(rl), 32'd16);
      check("f1_rises_high", 32'(rh), 32'd1);
      check("f1_period", 32'(per), 32'd78);
      check("f1_valids", 32'(vals), 32'd0);
      check("f1_sample", 32'(vs), 32'h000);
      check("f1_count", 32'(fr_if.frame_count), 32'd1);

      run_frame(-1, lows, rl, rh, per, vals, vs);
      check("f2_ss_low_cycles", 32'(lows), 32'd68);
      check("f2_rises_low", 32'(rl), 32'd16);
      check("f2_period", 32'(per), 32'd78);
      check("f2_valids", 32'(vals), 32'd1);
      check("f2_sample", 32'(vs), 32'hA5C);
      check("f2_count", 32'(fr_if.frame_count), 32'd2);

      // Enable dropped during SHIFT: frame completes, no further frame.
      run_frame(10, lows, rl, rh, per, vals, vs);
      check("f3_ss_low_cycles", 32'(lows), 32'd68);
      check("f3_rises_low", 32'(rl), 32'd16);
      check("f3_rises_high", 32'(rh), 32'd1);
      check("f3_no_restart", 32'(per), 32'd0);
      check("f3_count", 32'(fr_if.frame_count), 32'd3);
      check("f3_idle", 32'(fr_if.busy), 32'd0);

      // Reset during SHIFT, then a discarded frame wraps a preloaded count.
      fr_if.enable = 1'b1;
      wait_frame_start(found);
      check("f4_start", 32'(found), 32'd1);
      tick(10);
      check("f4_pre_rst_spi", 32'(fr_if.spi_clock), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_ss", 32'(fr_if.adc_ss), 32'd1);
      check("mid_rst_spi", 32'(fr_if.spi_clock), 32'd0);
      check("mid_rst_busy", 32'(fr_if.busy), 32'd0);
      check("mid_rst_sample", 32'(fr_if.sample), 32'h000);
      check("mid_rst_count", 32'(fr_if.frame_count), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      wait_frame_start(found);
      check("f5_start", 32'(found), 32'd1);
      force dut_fr.frame_count_r = 16'hFFFF;
      tick(1);
      release dut_fr.frame_count_r;
      run_frame(-1, lows, rl, rh, per, vals, vs);
      check("f5_discard_valids", 32'(vals), 32'd0);
      check("f5_wrap_count", 32'(fr_if.frame_count), 32'h0000);
      fr_if.enable = 1'b0;

      // Single-shot instance.
      ss_if.enable = 1'b1;
      tick(20);
      check("ss_no_free_run", 32'(ss_if.busy), 32'd0);
      ss_if.start = 1'b1;
      tick(1);
      ss_if.start = 1'b0;
      check("ss_start_latency", 32'(ss_if.adc_ss), 32'd0);
      run_single(10, k, falls, vals);
      check("ss_busy_cycles", 32'(k), 32'd77);
      check("ss_second_pulse_dropped", 32'(falls), 32'd0);
      check("ss_discard_valids", 32'(vals), 32'd0);
      tick(20);
      check("ss_stays_idle", 32'(ss_if.adc_ss), 32'd1);
      check("ss_count1", 32'(ss_if.frame_count), 32'd1);
      ss_if.start = 1'b1;
      tick(1);
      ss_if.start = 1'b0;
      check("ss_restart_latency", 32'(ss_if.adc_ss), 32'd0);
      run_single(-1, k, falls, vals);
      check("ss2_busy_cycles", 32'(k), 32'd77);
      check("ss2_valids", 32'(vals), 32'd1);
      check("ss2_sample", 32'(ss_if.sample), 32'h3C7);
      check("ss_count2", 32'(ss_if.frame_count), 32'd2);

      ss_if.enable = 1'b0;
      ss_if.start  = 1'b1;
      tick(1);
      ss_if.start  = 1'b0;
      tick(2);
      check("ss_disabled_start", 32'(ss_if.adc_ss), 32'd1);
      check("ss_disabled_busy", 32'(ss_if.busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/adc_frame_sequencer.md
# adc_frame_sequencer

- Generates the SPI framing that drives the ADC capture stage.
- Divides the system clock down to `SPIClock`, drives the active-low `ADCss` select for 16-bit conversion frames, and runs frames free-running or on request.
- After each frame, latches the capture stage's 12-bit `ADCbus` result into a stable `Sample` register with a one-cycle `SampleValid` strobe for downstream logic.
- Sits directly upstream of the SPI capture stage: it owns `SPIClock` and `ADCss`, and consumes that stage's `ADCbus`.

## Interface
- `CLK_DIV`, 25: `SPIClock` half-period in `Clock` cycles, ≥1. The default gives 1 MHz from 50 MHz.
- `IDLE_CYCLES`, 50: `Clock` cycles of quiet gap (`ADCss` high, `SPIClock` low) after the flush pulse, ≥0.
- `FREE_RUN`, 1: 1 = frames repeat while `Enable` is high; 0 = one frame per `Start` pulse.
- `Clock`  in  1  system clock; all logic on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Enable`  in  1  frame permission; sampled only in IDLE.
- `Start`  in  1  single-cycle frame request; used when `FREE_RUN`=0, ignored while `Busy`.
- `ADCbus`  in  12  conversion result from the capture stage.
- `SPIClock`  out  1  registered SPI clock.
- `ADCss`  out  1  registered active-low ADC select.
- `Sample`  out  12  last valid conversion.
- `SampleValid`  out  1  one-cycle strobe; `Sample` updated this cycle.
- `Busy`  out  1  high in every state except IDLE.
- `FrameCount`  out  16  completed frames, including the discarded first frame; wraps 0xFFFF→0.

## Operation
- States: IDLE, SETUP, SHIFT, HOLD, LATCH, FLUSH, GAP.
- A single divider counter (0..`CLK_DIV`-1) times every state. A 5-bit edge counter counts `SPIClock` rising edges in SHIFT.
- IDLE: `ADCss`=1, `SPIClock`=0.
  - Enter SETUP when `Enable`=1 and either `FREE_RUN`=1 or `Start`=1.
- SETUP: `ADCss`=0, `SPIClock`=0 for `CLK_DIV` cycles.
- SHIFT: `SPIClock` toggles every `CLK_DIV` cycles, starting high.
  - Exactly 16 rising edges.
  - Leave SHIFT after the 16th falling edge, with `SPIClock`=0.
- HOLD: `ADCss`=0, `SPIClock`=0 for `CLK_DIV` cycles.
- LATCH (1 cycle): `ADCss`=1; `FrameCount`+1.
  - First frame after reset: discarded; `Sample` unchanged, no strobe.
  - Every later frame: `Sample`←`ADCbus`, `SampleValid`=1.
- FLUSH: `ADCss`=1 while `SPIClock` is driven high for `CLK_DIV` cycles, then low for `CLK_DIV` cycles.
  - Mandatory: the capture stage clears its bit counter only on an `SPIClock` rising edge with `ADCss` high.
- GAP: `ADCss`=1, `SPIClock`=0 for `IDLE_CYCLES` cycles, then go to IDLE.
  - With `IDLE_CYCLES`=0, GAP lasts 0 cycles.
- `Enable` deasserted mid-frame: the frame and its FLUSH/GAP complete, then the block stays in IDLE.
- `Start` while `Busy`: dropped, not queued.
- `Start` and `Enable`=0 together: no frame.

## Timing
- Reset values: `SPIClock`=0, `ADCss`=1, `Sample`=0, `SampleValid`=0, `Busy`=0, `FrameCount`=0, state IDLE, discard flag set.
- Reset mid-frame: every output returns to its reset value asynchronously. The next frame after release is again discarded.
- All outputs are registered, with no combinational path from inputs to outputs.
- Frame length with D=`CLK_DIV`, from the first cycle with `ADCss`=0 to LATCH: D + 32D + D = 34D cycles.
  - `ADCss` rises in the LATCH cycle.
- Full free-running period = 34D + 1 + 2D + `IDLE_CYCLES` + 1 (IDLE decision cycle).
  - Defaults: 850+1+50+50+1 = 952 cycles.
- `Start` to `ADCss` falling: 1 cycle (registered).
- `ADCbus` is stable at least 2D cycles before LATCH, because its last update is on the 16th rising edge. No synchronizer is used; `SPIClock` is derived from `Clock`.

## Test plan
- **Reset values:** `Reset` high, then released with `Enable`=0 → `ADCss`=1, `SPIClock`=0, `Busy`=0, and no `SPIClock` edges for 200 cycles.
- **Frame shape:** `CLK_DIV`=2, `IDLE_CYCLES`=4, `FREE_RUN`=1, `Enable`=1.
  - `ADCss` low for exactly 68 cycles, with exactly 16 `SPIClock` rising edges in that window.
  - Exactly 1 rising edge while `ADCss` is high; period 78 cycles.
- **Discard and latch:** `ADCbus` held at 0xA5C.
  - First LATCH: no `SampleValid`, `Sample`=0x000, `FrameCount`=1.
  - Second LATCH: `SampleValid` for 1 cycle, `Sample`=0xA5C, `FrameCount`=2.
- **Single-shot mode:** `FREE_RUN`=0; `Start` pulse, plus a second pulse 10 cycles later.
  - Exactly one frame runs, and the second pulse is ignored.
  - A pulse given after `Busy` falls starts a new frame 1 cycle later.
- **`Enable` dropped mid-frame:** `Enable`=0 during SHIFT → the frame finishes all 16 edges, LATCH and FLUSH, then IDLE; no further `ADCss` low.
- **Reset mid-frame and wrap:** `Reset` during SHIFT → `ADCss`=1 and `SPIClock`=0 in the same cycle, and the next frame is discarded. Preload via force `FrameCount`=0xFFFF, then complete a frame → `FrameCount`=0x0000.
